// File: rtl/sd_image_writer.sv
// Purpose : streams one 76800-pixel frame-buffer image to an initialised SDHC card as CMD24 single-block writes.
// Latency : roughly 530 byte exchanges per block (command, R1, token, 512 data bytes, CRC, response, busy).
// Backpress: one byte in flight on the SPI engine; each next byte waits for spi_done_i of the previous one.
//
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   start_i, image_index_i          start pulse and image slot (sampled on an accepted start)
//   busy_o, done_o, error_o         status; done/error hold until the next accepted start
//   err_code_o                      1 = R1 bad/timeout, 2 = data response rejected, 3 = busy timeout
//   fb_addr_o, fb_data_i            frame-buffer read port (data valid one cycle after the address)
//   spi_cs_n_o                      card chip select, active low
//   spi_start_o, spi_data_in_o      byte launch pulse and byte to transmit
//   spi_done_i, spi_data_out_i      byte complete pulse and received byte
module sd_image_writer #(
   parameter int BLOCKS_PER_IMAGE = 300,
   parameter int R1_TIMEOUT       = 8,
   parameter int BUSY_TIMEOUT     = 65535
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   input  logic [1:0]  image_index_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   output logic [1:0]  err_code_o,
   output logic [16:0] fb_addr_o,
   input  logic [15:0] fb_data_i,
   output logic        spi_cs_n_o,
   output logic        spi_start_o,
   output logic [7:0]  spi_data_in_o,
   input  logic        spi_done_i,
   input  logic [7:0]  spi_data_out_i
);

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_R1, S_GAP, S_TOKEN, S_FETCH, S_DATA_HI, S_DATA_LO,
      S_CRC, S_DRESP, S_BUSY, S_NEXT, S_DONE, S_ERROR
   } state_t;

   localparam logic [16:0] R1_LAST   = 17'(R1_TIMEOUT - 1);
   localparam logic [16:0] BUSY_LAST = 17'(BUSY_TIMEOUT - 1);
   localparam logic [8:0]  BLK_LAST  = 9'(BLOCKS_PER_IMAGE - 1);

   state_t      state_q;
   logic        wait_q;        // a byte is outstanding on the SPI engine
   logic [1:0]  img_q;
   logic [8:0]  blk_q;
   logic [7:0]  pix_q;         // pixel_in_block
   logic [2:0]  cnt_q;         // byte index inside CMD / CRC
   logic [16:0] poll_q;        // R1 / busy poll counter
   logic [15:0] pix_dat_q;
   logic        busy_q;
   logic        done_q;
   logic        error_q;
   logic [1:0]  err_code_q;
   logic [16:0] fb_addr_q;
   logic        cs_n_q;
   logic        spi_start_q;
   logic [7:0]  spi_dat_q;

   logic [31:0] blk_addr_d;
   logic [7:0]  tx_byte_d;
   logic        byte_state_d;
   logic        rx_vld_d;

   assign blk_addr_d   = 32'(img_q) * 32'(BLOCKS_PER_IMAGE) + 32'(blk_q);
   assign byte_state_d = state_q inside {S_CMD, S_R1, S_GAP, S_TOKEN, S_DATA_HI,
                                         S_DATA_LO, S_CRC, S_DRESP, S_BUSY};
   // Only a spi_done that answers our own launch is acted upon.
   assign rx_vld_d     = wait_q && spi_done_i;

   always_comb begin
      tx_byte_d = 8'hFF;
      case (state_q)
         S_CMD: begin
            case (cnt_q)
               3'd0:    tx_byte_d = 8'h58;
               3'd1:    tx_byte_d = blk_addr_d[31:24];
               3'd2:    tx_byte_d = blk_addr_d[23:16];
               3'd3:    tx_byte_d = blk_addr_d[15:8];
               3'd4:    tx_byte_d = blk_addr_d[7:0];
               default: tx_byte_d = 8'hFF;
            endcase
         end
         S_TOKEN:   tx_byte_d = 8'hFE;
         S_DATA_HI: tx_byte_d = pix_dat_q[15:8];
         S_DATA_LO: tx_byte_d = pix_dat_q[7:0];
         default:   tx_byte_d = 8'hFF;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         wait_q      <= 1'b0;
         img_q       <= 2'd0;
         blk_q       <= 9'd0;
         pix_q       <= 8'd0;
         cnt_q       <= 3'd0;
         poll_q      <= 17'd0;
         pix_dat_q   <= 16'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_code_q  <= 2'd0;
         fb_addr_q   <= 17'd0;
         cs_n_q      <= 1'b1;
         spi_start_q <= 1'b0;
         spi_dat_q   <= 8'hFF;
      end else begin
         spi_start_q <= 1'b0;

         // Launch the current state's byte whenever nothing is in flight.
         if (byte_state_d && !wait_q) begin
            spi_start_q <= 1'b1;
            spi_dat_q   <= tx_byte_d;
            wait_q      <= 1'b1;
            if (state_q == S_TOKEN)
               fb_addr_q <= {blk_q, 8'h00};
            // Present the next pixel address while the low byte is still on the
            // wire, so the registered RAM output is settled by the FETCH cycle.
            if (state_q == S_DATA_LO && pix_q != 8'hFF)
               fb_addr_q <= {blk_q, pix_q + 8'd1};
         end

         if (rx_vld_d)
            wait_q <= 1'b0;

         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start_i) begin
                  img_q      <= image_index_i;
                  blk_q      <= 9'd0;
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
                  err_code_q <= 2'd0;
                  busy_q     <= 1'b1;
                  cs_n_q     <= 1'b0;
                  cnt_q      <= 3'd0;
                  wait_q     <= 1'b0;
                  state_q    <= S_CMD;
               end
            end

            S_CMD: begin
               if (rx_vld_d) begin
                  if (cnt_q == 3'd5) begin
                     cnt_q   <= 3'd0;
                     poll_q  <= 17'd0;
                     state_q <= S_R1;
                  end else begin
                     cnt_q <= cnt_q + 3'd1;
                  end
               end
            end

            S_R1: begin
               if (rx_vld_d) begin
                  if (spi_data_out_i == 8'h00) begin
                     state_q <= S_GAP;
                  end else if (spi_data_out_i != 8'hFF || poll_q == R1_LAST) begin
                     state_q    <= S_ERROR;
                     busy_q     <= 1'b0;
                     error_q    <= 1'b1;
                     cs_n_q     <= 1'b1;
                     err_code_q <= 2'd1;
                  end else begin
                     poll_q <= poll_q + 17'd1;
                  end
               end
            end

            S_GAP: begin
               if (rx_vld_d)
                  state_q <= S_TOKEN;
            end

            S_TOKEN: begin
               if (rx_vld_d) begin
                  pix_q   <= 8'd0;
                  state_q <= S_FETCH;
               end
            end

            S_FETCH: begin
               pix_dat_q <= fb_data_i;
               state_q   <= S_DATA_HI;
            end

            S_DATA_HI: begin
               if (rx_vld_d)
                  state_q <= S_DATA_LO;
            end

            S_DATA_LO: begin
               if (rx_vld_d) begin
                  if (pix_q != 8'hFF) begin
                     pix_q   <= pix_q + 8'd1;
                     state_q <= S_FETCH;
                  end else begin
                     cnt_q   <= 3'd0;
                     state_q <= S_CRC;
                  end
               end
            end

            S_CRC: begin
               if (rx_vld_d) begin
                  if (cnt_q == 3'd1)
                     state_q <= S_DRESP;
                  else
                     cnt_q <= cnt_q + 3'd1;
               end
            end

            S_DRESP: begin
               if (rx_vld_d) begin
                  if (spi_data_out_i[4:0] == 5'b00101) begin
                     poll_q  <= 17'd0;
                     state_q <= S_BUSY;
                  end else begin
                     state_q    <= S_ERROR;
                     busy_q     <= 1'b0;
                     error_q    <= 1'b1;
                     cs_n_q     <= 1'b1;
                     err_code_q <= 2'd2;
                  end
               end
            end

            S_BUSY: begin
               if (rx_vld_d) begin
                  if (spi_data_out_i != 8'h00) begin
                     state_q <= S_NEXT;
                  end else if (poll_q == BUSY_LAST) begin
                     state_q    <= S_ERROR;
                     busy_q     <= 1'b0;
                     error_q    <= 1'b1;
                     cs_n_q     <= 1'b1;
                     err_code_q <= 2'd3;
                  end else begin
                     poll_q <= poll_q + 17'd1;
                  end
               end
            end

            S_NEXT: begin
               if (blk_q == BLK_LAST) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cs_n_q  <= 1'b1;
               end else begin
                  blk_q   <= blk_q + 9'd1;
                  cnt_q   <= 3'd0;
                  state_q <= S_CMD;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign error_o       = error_q;
   assign err_code_o    = err_code_q;
   assign fb_addr_o     = fb_addr_q;
   assign spi_cs_n_o    = cs_n_q;
   assign spi_start_o   = spi_start_q;
   assign spi_data_in_o = spi_dat_q;

endmodule

// File: tb/tb_sd_image_writer.sv
// Purpose : directed bench for sd_image_writer with an SD card model and frame-buffer model.
// Latency : card answers each byte one cycle after spi_start; RAM is a one-cycle registered read.
// Backpress: card model holds one byte in flight and flags any protocol violation.
module tb_sd_image_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  image_index;
   logic        busy, done, error;
   logic [1:0]  err_code;
   logic [16:0] fb_addr;
   logic [15:0] fb_data = 16'd0;
   logic        spi_cs_n, spi_start;
   logic [7:0]  spi_data_in;
   logic        spi_done;
   logic [7:0]  spi_data_out;

   always #5 clk = ~clk;

   // Reduced geometry: 12 blocks per image, 40-poll busy limit.
   sd_image_writer #(.BLOCKS_PER_IMAGE(12), .R1_TIMEOUT(8), .BUSY_TIMEOUT(40)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .image_index_i(image_index),
      .busy_o(busy), .done_o(done), .error_o(error), .err_code_o(err_code),
      .fb_addr_o(fb_addr), .fb_data_i(fb_data),
      .spi_cs_n_o(spi_cs_n), .spi_start_o(spi_start), .spi_data_in_o(spi_data_in),
      .spi_done_i(spi_done), .spi_data_out_i(spi_data_out)
   );

   // Frame buffer holds fb_data = addr[15:0], registered read.
   always @(posedge clk) fb_data <= fb_addr[15:0];

   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // ---------------- card model ----------------
   int          cph, ccnt, dcnt, cmd_count, tokens, r1_polls, b_polls, viol;
   int          r1_mode, dresp_bad_blk;
   bit          busy_forever, lo10;
   logic [7:0]  cmd_buf [6];
   logic [47:0] first_cmd;
   logic [31:0] last_addr;
   logic [7:0]  cap [$];

   task automatic card_init();
      cph = 0; ccnt = 0; dcnt = 0; cmd_count = 0; tokens = 0;
      r1_polls = 0; b_polls = 0; viol = 0; lo10 = 1'b0;
      r1_mode = 0; dresp_bad_blk = -1; busy_forever = 1'b0;
      first_cmd = 48'd0; last_addr = 32'hFFFF_FFFF;
      cap.delete();
   endtask

   task automatic card_byte(input logic [7:0] tx, output logic [7:0] rx);
      int cur_blk;
      cur_blk = cmd_count - 1;
      rx = 8'hFF;
      case (cph)
         0: if (tx == 8'h58) begin cmd_buf[0] = tx; ccnt = 1; cph = 1; end
         1: begin
            cmd_buf[ccnt] = tx;
            ccnt++;
            if (ccnt == 6) begin
               cmd_count++;
               if (cmd_count == 1)
                  first_cmd = {cmd_buf[0], cmd_buf[1], cmd_buf[2], cmd_buf[3], cmd_buf[4], cmd_buf[5]};
               last_addr = {cmd_buf[1], cmd_buf[2], cmd_buf[3], cmd_buf[4]};
               r1_polls = 0;
               cph = 2;
            end
         end
         2: begin
            r1_polls++;
            if (r1_mode != 2 && r1_polls == 2) begin
               if (r1_mode == 1) begin rx = 8'h04; cph = 0; end
               else begin rx = 8'h00; cph = 3; end
            end
         end
         3: if (tx == 8'hFE) begin
            tokens++;
            dcnt = 0;
            cph = 4;
            if (cur_blk == 2) cap.push_back(tx);
         end
         4: begin
            if (cur_blk == 2) cap.push_back(tx);
            if (cur_blk == 10 && dcnt < 512 && dcnt % 2 == 1) lo10 = 1'b1;
            dcnt++;
            if (dcnt == 514) cph = 5;
         end
         5: begin
            if (cur_blk == dresp_bad_blk) begin rx = 8'h0B; cph = 0; end
            else begin rx = 8'hE5; b_polls = 0; cph = 6; end
         end
         6: begin
            b_polls++;
            if (busy_forever || b_polls <= 3) rx = 8'h00;
            else begin rx = 8'hFF; cph = 0; end
         end
         default: cph = 0;
      endcase
   endtask

   logic [7:0] c_tx, c_rx;
   initial begin
      spi_done = 1'b0;
      spi_data_out = 8'hFF;
      forever begin
         @(posedge clk); #1;
         if (spi_start && !reset) begin
            c_tx = spi_data_in;
            if (spi_cs_n) viol++;
            card_byte(c_tx, c_rx);
            @(posedge clk); #1;
            if (!reset) begin
               if (spi_start) viol++;
               if (spi_data_in !== c_tx) viol++;
            end
            spi_done = 1'b1;
            spi_data_out = c_rx;
            @(posedge clk); #1;
            spi_done = 1'b0;
            spi_data_out = 8'hFF;
         end
      end
   end

   // fb_addr must advance by exactly one whenever it changes.
   bit          mon_en = 1'b0;
   int          fb_bad;
   logic [16:0] fb_prev;
   always @(negedge clk) begin
      if (mon_en && fb_addr != fb_prev) begin
         if (fb_addr != fb_prev + 17'd1) fb_bad++;
         fb_prev = fb_addr;
      end
   end

   task automatic pulse_start(input logic [1:0] img);
      image_index = img;
      start = 1'b1;
      tick();
      start = 1'b0;
      image_index = 2'd0;
   endtask

   task automatic wait_end(input int bound);
      int n;
      n = 0;
      while (!(done || error) && n < bound) begin tick(); n++; end
      chk("run_end_reached", {63'd0, (done || error)}, 64'd1);
   endtask

   initial begin
      int mism, n;
      card_init();
      reset = 1'b1; start = 1'b0; image_index = 2'd0;
      repeat (3) tick();
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_error", {63'd0, error}, 64'd0);
      chk("rst_err_code", {62'd0, err_code}, 64'd0);
      chk("rst_fb_addr", {47'd0, fb_addr}, 64'd0);
      chk("rst_cs_n", {63'd0, spi_cs_n}, 64'd1);
      chk("rst_spi_start", {63'd0, spi_start}, 64'd0);
      chk("rst_spi_data_in", {56'd0, spi_data_in}, 64'hFF);
      reset = 1'b0;
      tick();

      // Run 1: image 1, card acks everything; a start during busy must be ignored.
      card_init();
      fb_prev = 17'd0; fb_bad = 0; mon_en = 1'b1;
      pulse_start(2'd1);
      chk("r1_busy_after_start", {63'd0, busy}, 64'd1);
      chk("r1_cs_low", {63'd0, spi_cs_n}, 64'd0);
      repeat (2000) tick();
      chk("r1_busy_mid", {63'd0, busy}, 64'd1);
      pulse_start(2'd3);
      wait_end(40000);
      mon_en = 1'b0;
      chk("r1_done", {63'd0, done}, 64'd1);
      chk("r1_busy_end", {63'd0, busy}, 64'd0);
      chk("r1_error", {63'd0, error}, 64'd0);
      chk("r1_cs_high", {63'd0, spi_cs_n}, 64'd1);
      chk("r1_first_cmd", {16'd0, first_cmd}, 64'h58_00_00_00_0C_FF);
      chk("r1_cmd_count", 64'(cmd_count), 64'd12);
      chk("r1_last_addr", {32'd0, last_addr}, 64'h17);
      chk("r1_tokens", 64'(tokens), 64'd12);
      chk("r1_fb_steps", 64'(fb_bad), 64'd0);
      chk("r1_fb_last", {47'd0, fb_prev}, 64'd3071);
      chk("r1_blk2_len", 64'(cap.size()), 64'd515);
      if (cap.size() == 515) begin
         chk("r1_blk2_token", {56'd0, cap[0]}, 64'hFE);
         mism = 0;
         for (int k = 0; k < 256; k++)
            if (cap[1 + 2 * k] !== 8'h02 || cap[2 + 2 * k] !== 8'(k)) mism++;
         chk("r1_blk2_data", 64'(mism), 64'd0);
         chk("r1_blk2_crc", {48'd0, cap[513], cap[514]}, 64'hFFFF);
      end
      chk("r1_protocol", 64'(viol), 64'd0);

      // Run 2: R1 = 04 on the first CMD24.
      card_init();
      r1_mode = 1;
      pulse_start(2'd2);
      chk("r2_done_cleared", {63'd0, done}, 64'd0);
      wait_end(5000);
      chk("r2_error", {63'd0, error}, 64'd1);
      chk("r2_err_code", {62'd0, err_code}, 64'd1);
      chk("r2_busy", {63'd0, busy}, 64'd0);
      chk("r2_cs_high", {63'd0, spi_cs_n}, 64'd1);
      chk("r2_no_token", 64'(tokens), 64'd0);
      chk("r2_first_cmd", {16'd0, first_cmd}, 64'h58_00_00_00_18_FF);

      // Run 3: restart from block 0, data response rejected on block 5.
      card_init();
      dresp_bad_blk = 5;
      pulse_start(2'd0);
      chk("r3_error_cleared", {63'd0, error}, 64'd0);
      chk("r3_err_code_cleared", {62'd0, err_code}, 64'd0);
      wait_end(30000);
      chk("r3_err_code", {62'd0, err_code}, 64'd2);
      chk("r3_first_cmd", {16'd0, first_cmd}, 64'h58_00_00_00_00_FF);
      chk("r3_cmd_count", 64'(cmd_count), 64'd6);
      chk("r3_protocol", 64'(viol), 64'd0);

      // Run 4: card stays busy forever on block 0.
      card_init();
      busy_forever = 1'b1;
      pulse_start(2'd0);
      wait_end(10000);
      chk("r4_err_code", {62'd0, err_code}, 64'd3);
      chk("r4_busy_polls", 64'(b_polls), 64'd40);
      chk("r4_tokens", 64'(tokens), 64'd1);

      // Run 5: reset while the low byte of a block-10 pixel is in flight.
      card_init();
      pulse_start(2'd1);
      n = 0;
      while (!lo10 && n < 30000) begin @(posedge clk); #2; n++; end
      chk("r5_blk10_reached", {63'd0, lo10}, 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("r5_rst_busy", {63'd0, busy}, 64'd0);
      chk("r5_rst_cs_high", {63'd0, spi_cs_n}, 64'd1);
      chk("r5_rst_fb_addr", {47'd0, fb_addr}, 64'd0);
      chk("r5_rst_spi_start", {63'd0, spi_start}, 64'd0);
      #2 reset = 1'b0;
      tick(); tick();
      chk("r5_idle_ignores_done", {62'd0, busy, spi_start}, 64'd0);
      card_init();
      r1_mode = 2;
      pulse_start(2'd1);
      wait_end(5000);
      chk("r5_first_cmd", {16'd0, first_cmd}, 64'h58_00_00_00_0C_FF);
      chk("r5_r1_timeout_code", {62'd0, err_code}, 64'd1);
      chk("r5_r1_polls", 64'(r1_polls), 64'd8);
      chk("r5_protocol", 64'(viol), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
